des_cbc_ctrl: RTL and testbench

- Upstream mode controller for the DES core. It drives the core's plain_text, cipher_key, valid_in and encrypt_decrypt inputs, and consumes its valid_out and cipher_text outputs.
- Implements CBC chaining: encrypt C_i = E(P_i ^ C_{i-1}); decrypt P_i = D(C_i) ^ C_{i-1}, with C_0 = IV.
- Host side uses valid/ready in and valid/ready out. One block in flight at a time, because CBC encryption is serially dependent.

---
 rtl/des_cbc_ctrl_pkg.sv | 24 ++
 rtl/des_cbc_ctrl_xor.sv | 17 +
 rtl/des_cbc_ctrl.sv | 173 +++++++++++++++++
 tb/tb_des_cbc_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_cbc_ctrl_pkg.sv
// des_cbc_ctrl_pkg: shared types and defaults for the DES CBC mode controller.
//   - cbc_state_e : controller FSM state encoding (3 bits)
//   - DEFAULT_CORE_LAT : DES core pipeline depth, built from the key-schedule,
//     round and I/O flop stage counts of the core
//   - DEFAULT_WDOG_SLACK : extra cycles tolerated before the watchdog fires
package des_cbc_ctrl_pkg;

    localparam int unsigned NUM_KEY_STAGES_FF   = 2;
    localparam int unsigned NUM_ROUND_STAGES_FF = 16;
    localparam int unsigned NUM_IO_STAGES_FF    = 2;

    localparam int unsigned DEFAULT_CORE_LAT =
        NUM_KEY_STAGES_FF + NUM_ROUND_STAGES_FF + NUM_IO_STAGES_FF;
    localparam int unsigned DEFAULT_WDOG_SLACK = 8;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReady = 3'd1,
        StIssue = 3'd2,
        StWait  = 3'd3,
        StOut   = 3'd4
    } cbc_state_e;

endpackage

// File: rtl/des_cbc_ctrl_xor.sv
// des_cbc_ctrl_xor: combinational CBC chain XOR with bypass.
//   data  in  64  block entering the chain operation
//   chain in  64  current chain value (IV or previous ciphertext)
//   pass  in  1   1 = forward data unchanged, 0 = data ^ chain
//   y     out 64  result
module des_cbc_ctrl_xor (
    input  logic [63:0] data,
    input  logic [63:0] chain,
    input  logic        pass,
    output logic [63:0] y
);

    always_comb begin
        y = pass ? data : (data ^ chain);
    end

endmodule

// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl: CBC mode controller in front of a fixed-latency DES core.
// Encrypt: C_i = E(P_i ^ C_{i-1}); decrypt: P_i = D(C_i) ^ C_{i-1}; C_0 = IV.
// One block in flight at a time.
// Ports:
//   clk, rstn                     clock, async active-low reset
//   iv_load, iv, key, decrypt     start a new chain (latches iv/key/mode)
//   in_data, in_valid, in_ready   host input block handshake
//   out_data, out_valid, out_ready host result handshake
//   core_*                        DES core request/response
//   busy                          block in ISSUE/WAIT/OUT
//   wdog_err                      sticky core timeout error
// Optional feature: define DES_CBC_WDOG_EN to enable the WAIT-state watchdog;
// otherwise wdog_err is tied 0 and WAIT waits indefinitely.
module des_cbc_ctrl
    import des_cbc_ctrl_pkg::*;
#(
    parameter int unsigned CORE_LAT   = DEFAULT_CORE_LAT,
    parameter int unsigned WDOG_SLACK = DEFAULT_WDOG_SLACK
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        iv_load,
    input  logic [63:0] iv,
    input  logic [63:0] key,
    input  logic        decrypt,
    input  logic [63:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] core_plain_text,
    output logic [63:0] core_cipher_key,
    output logic        core_valid_in,
    output logic        core_encrypt_decrypt,
    input  logic        core_valid_out,
    input  logic [63:0] core_cipher_text,
    output logic        busy,
    output logic        wdog_err
);

    localparam int unsigned LIMIT = CORE_LAT + WDOG_SLACK;
    localparam int unsigned CW    = $clog2(LIMIT + 1);

    cbc_state_e  state_q, state_d;
    logic [63:0] chain_q, chain_d;
    logic [63:0] key_q, key_d;
    logic        mode_q, mode_d;
    logic [63:0] blk_q, blk_d;
    logic [63:0] out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        wdog_q, wdog_d;
    // Last issued core request, so the core inputs stay put outside ISSUE.
    logic [63:0] pt_hold_q, key_hold_q;
    logic        ed_hold_q;

    logic [63:0] issue_pt, result;

    // Encrypt whitens the plaintext before the core; decrypt passes it through.
    des_cbc_ctrl_xor u_issue_xor (
        .data  (blk_q),
        .chain (chain_q),
        .pass  (mode_q),
        .y     (issue_pt)
    );

    // Decrypt unwhitens the core output; encrypt passes it through.
    des_cbc_ctrl_xor u_result_xor (
        .data  (core_cipher_text),
        .chain (chain_q),
        .pass  (~mode_q),
        .y     (result)
    );

    always_comb begin
        state_d = state_q;
        chain_d = chain_q;
        key_d   = key_q;
        mode_d  = mode_q;
        blk_d   = blk_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        wdog_d  = wdog_q;
        unique case (state_q)
            StIdle, StReady: begin
                // iv_load wins over a simultaneous in_valid in READY.
                if (iv_load) begin
                    chain_d = iv;
                    key_d   = key;
                    mode_d  = decrypt;
                    state_d = StReady;
                end else if (state_q == StReady && in_valid) begin
                    blk_d   = in_data;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (core_valid_out) begin
                    out_d   = result;
                    chain_d = mode_q ? blk_q : core_cipher_text;
                    state_d = StOut;
                end else begin
                    if (cnt_q != CW'(LIMIT)) begin
                        cnt_d = cnt_q + 1'b1;
                    end
`ifdef DES_CBC_WDOG_EN
                    if (cnt_q == CW'(LIMIT)) begin
                        wdog_d  = 1'b1;
                        state_d = StIdle;
                    end
`endif
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StReady;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= StIdle;
            chain_q    <= '0;
            key_q      <= '0;
            mode_q     <= 1'b0;
            blk_q      <= '0;
            out_q      <= '0;
            cnt_q      <= '0;
            wdog_q     <= 1'b0;
            pt_hold_q  <= '0;
            key_hold_q <= '0;
            ed_hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            chain_q <= chain_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            blk_q   <= blk_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
            if (state_q == StIssue) begin
                pt_hold_q  <= issue_pt;
                key_hold_q <= key_q;
                ed_hold_q  <= mode_q;
            end
        end
    end

    always_comb begin
        core_valid_in        = (state_q == StIssue);
        core_plain_text      = core_valid_in ? issue_pt : pt_hold_q;
        core_cipher_key      = core_valid_in ? key_q : key_hold_q;
        core_encrypt_decrypt = core_valid_in ? mode_q : ed_hold_q;
        in_ready             = (state_q == StReady);
        out_valid            = (state_q == StOut);
        out_data             = out_q;
        busy                 = (state_q != StIdle) && (state_q != StReady);
`ifdef DES_CBC_WDOG_EN
        wdog_err             = wdog_q;
`else
        wdog_err             = 1'b0;
`endif
    end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// tb_des_cbc_ctrl: directed self-checking bench for des_cbc_ctrl with a
// fixed-latency stand-in DES core (known-answer pair plus an invertible toy map).
module tb_des_cbc_ctrl;

    localparam int unsigned LAT   = 20;
    localparam int unsigned SLACK = 8;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] P0  = 64'h0123456789ABCDEF;
    localparam logic [63:0] C1  = 64'h85E813540F0AB405;
    localparam logic [63:0] X2  = 64'h84CB563386A179EA; // P0 ^ C1
    localparam logic [63:0] C2  = 64'h97FF014A1D1DA61B; // toy E(X2) = X2 ^ KEY

    logic        clk = 1'b0;
    logic        rstn;
    logic        iv_load;
    logic [63:0] iv;
    logic [63:0] key;
    logic        decrypt;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] core_plain_text;
    logic [63:0] core_cipher_key;
    logic        core_valid_in;
    logic        core_encrypt_decrypt;
    logic        core_valid_out;
    logic [63:0] core_cipher_text;
    logic        busy;
    logic        wdog_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    des_cbc_ctrl #(
        .CORE_LAT   (LAT),
        .WDOG_SLACK (SLACK)
    ) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .iv_load              (iv_load),
        .iv                   (iv),
        .key                  (key),
        .decrypt              (decrypt),
        .in_data              (in_data),
        .in_valid             (in_valid),
        .in_ready             (in_ready),
        .out_data             (out_data),
        .out_valid            (out_valid),
        .out_ready            (out_ready),
        .core_plain_text      (core_plain_text),
        .core_cipher_key      (core_cipher_key),
        .core_valid_in        (core_valid_in),
        .core_encrypt_decrypt (core_encrypt_decrypt),
        .core_valid_out       (core_valid_out),
        .core_cipher_text     (core_cipher_text),
        .busy                 (busy),
        .wdog_err             (wdog_err)
    );

    // Stand-in core: fixed LAT-cycle pipeline, independent of the DUT reset.
    logic        model_rst;
    logic        core_mute;
    logic [LAT-1:0] vpipe;
    logic [63:0] dpipe [LAT];

    function automatic logic [63:0] toy_des(input logic [63:0] d, input logic [63:0] k,
                                            input logic dec);
        if (k == KEY && !dec && d == P0) return C1;
        if (k == KEY && dec && d == C1) return P0;
        return d ^ k;
    endfunction

    always @(posedge clk) begin
        if (model_rst) begin
            vpipe <= '0;
        end else begin
            vpipe <= {vpipe[LAT-2:0], core_valid_in};
        end
        dpipe[0] <= toy_des(core_plain_text, core_cipher_key, core_encrypt_decrypt);
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end

    assign core_valid_out   = vpipe[LAT-1] & ~core_mute;
    assign core_cipher_text = dpipe[LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load_chain(input logic [63:0] v, input logic dec);
        iv = v; key = KEY; decrypt = dec; iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
    endtask

    // Present a block; returns at the ISSUE negedge.
    task automatic send_block(input logic [63:0] d);
        in_data = d; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts negedges from ISSUE until out_valid, bounded.
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int cyc;

    initial begin
        rstn = 1'b0; model_rst = 1'b1; core_mute = 1'b0;
        iv_load = 1'b0; iv = '0; key = '0; decrypt = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_core_valid_in", core_valid_in, 0);
        check("rst_out_data", out_data, 0);
        check("rst_core_pt", core_plain_text, 0);
        check("rst_wdog", wdog_err, 0);
        rstn = 1'b1; model_rst = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 0);

        // Encrypt chain, block 1
        load_chain(64'h0, 1'b0);
        check("ready_in_ready", in_ready, 1);
        check("ready_busy", busy, 0);
        send_block(P0);
        check("enc1_valid_in", core_valid_in, 1);
        check("enc1_core_pt", core_plain_text, P0);
        check("enc1_core_key", core_cipher_key, KEY);
        check("enc1_core_ed", core_encrypt_decrypt, 0);
        check("enc1_busy", busy, 1);
        check("enc1_in_ready", in_ready, 0);
        tick();
        check("enc1_valid_in_pulse", core_valid_in, 0);
        check("enc1_core_pt_hold", core_plain_text, P0);
        wait_out(cyc);
        check("enc1_latency", 64'(cyc), 64'(LAT));
        check("enc1_out_data", out_data, C1);

        // Backpressure: hold out_ready low for 10 cycles
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", out_data, C1);
            check("hold_in_ready", in_ready, 0);
            check("hold_valid_in", core_valid_in, 0);
        end
        take_out();
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 0);

        // Encrypt chain, block 2 (chained on C1)
        send_block(P0);
        check("enc2_core_pt", core_plain_text, X2);
        wait_out(cyc);
        check("enc2_latency", 64'(cyc), 64'(LAT + 1));
        check("enc2_out_data", out_data, C2);
        take_out();

        // Decrypt chain (READY restart)
        load_chain(64'h0, 1'b1);
        check("dec_in_ready", in_ready, 1);
        send_block(C1);
        check("dec1_core_pt", core_plain_text, C1);
        check("dec1_core_ed", core_encrypt_decrypt, 1);
        wait_out(cyc);
        check("dec1_out_data", out_data, P0);
        take_out();
        send_block(C2);
        check("dec2_core_pt", core_plain_text, C2);
        wait_out(cyc);
        check("dec2_out_data", out_data, P0);
        take_out();

        // iv_load beats a simultaneous in_valid in READY
        iv = 64'h0; key = KEY; decrypt = 1'b0; iv_load = 1'b1;
        in_data = C2; in_valid = 1'b1;
        tick();
        iv_load = 1'b0; in_valid = 1'b0;
        check("prio_in_ready", in_ready, 1);
        check("prio_valid_in", core_valid_in, 0);
        check("prio_busy", busy, 0);

        // Fresh encrypt chain, then reset mid-WAIT
        send_block(P0);
        check("rstw_core_pt", core_plain_text, P0);
        check("rstw_core_ed", core_encrypt_decrypt, 0);
        tick(); tick();
        iv = 64'hFFFF_FFFF_FFFF_FFFF; decrypt = 1'b1; iv_load = 1'b1;
        tick();
        iv_load = 1'b0;
        check("wait_ignores_iv_load", busy, 1);
        tick(); tick();
        rstn = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_core_pt", core_plain_text, 0);
        check("arst_core_key", core_cipher_key, 0);
        check("arst_core_ed", core_encrypt_decrypt, 0);
        check("arst_valid_in", core_valid_in, 0);
        check("arst_out_data", out_data, 0);
        tick();
        rstn = 1'b1;
        for (int i = 0; i < LAT + 5; i++) tick();
        check("late_out_valid", out_valid, 0);
        check("late_in_ready", in_ready, 0);
        check("late_busy", busy, 0);
        check("late_out_data", out_data, 0);

        // Core never answers
        load_chain(64'h0, 1'b0);
        core_mute = 1'b1;
        send_block(P0);
`ifdef DES_CBC_WDOG_EN
        cyc = 0;
        while (!wdog_err && cyc < 100) begin
            tick();
            cyc++;
        end
        check("wdog_fired", wdog_err, 1);
        check("wdog_no_early", 64'(cyc >= LAT + SLACK), 64'd1);
        tick();
        check("wdog_idle_busy", busy, 0);
        check("wdog_idle_in_ready", in_ready, 0);
        check("wdog_out_valid", out_valid, 0);
        check("wdog_sticky", wdog_err, 1);
`else
        for (int i = 0; i < LAT + SLACK + 10; i++) tick();
        check("nowdog_err", wdog_err, 0);
        check("nowdog_busy", busy, 1);
        check("nowdog_out_valid", out_valid, 0);
`endif
        core_mute = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
